// File: rtl/mips16_pkg.sv
// Shared encodings for the 16-bit MIPS multi-cycle controller: opcodes, FSM states
// and the datapath select fields it drives.
package mips16_pkg;

    typedef enum logic [2:0] {
        OP_R    = 3'd0,
        OP_SLTI = 3'd1,
        OP_J    = 3'd2,
        OP_JAL  = 3'd3,
        OP_LW   = 3'd4,
        OP_SW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_ADDI = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_PLUS1  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_SLT  = 2'b10,
        ALU_ADDI = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        DST_RT   = 2'b00,
        DST_RD   = 2'b01,
        DST_LINK = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        M2R_ALU = 2'b00,
        M2R_MDR = 2'b01,
        M2R_PC1 = 2'b10
    } mem_to_reg_e;

    // A disabled watchdog (timeout 0) still needs a one-bit counter to stay legal.
    function automatic int tmo_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/mips16_ack_watchdog.sv
// Handshake wait counter: counts stalled req cycles and flags the cycle in which
// the count would reach the limit. A limit of zero disables the watchdog.
module mips16_ack_watchdog #(
    parameter int TMO_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

    logic [TMO_W-1:0] cnt_q;
    logic             enabled;

    assign enabled = (limit != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && enabled) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    // An ack in the limit cycle drops inc, so the ack wins over expiry.
    assign expired = inc && enabled && (cnt_q == (limit - ONE));

endmodule

// File: rtl/mips16_multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the 16-bit MIPS datapath with req/ack memory
// handshakes and a sticky timeout fault. Optional counters: MIPS16_CTRL_PERF_EN.
module mips16_multicycle_ctrl
    import mips16_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  opcode,
    input  logic        alu_zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  alu_op,
    output logic        alu_src,
    output logic        sign_or_zero,
    output logic        retire,
    output logic        fault,
    output logic [2:0]  state_o
`ifdef MIPS16_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
`endif
);

    localparam int TMO_W = tmo_width(ACK_TIMEOUT);

    ctrl_state_e state_q, state_d;
    opcode_e     op_q;
    logic        wd_inc, wd_clear, wd_expired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= OP_R;
        end else if (state_q == S_DECODE) begin
            op_q <= opcode_e'(opcode);
        end
    end

    assign wd_inc   = ((state_q == S_FETCH) && !imem_ack) ||
                      ((state_q == S_MEM)   && !dmem_ack);
    assign wd_clear = (state_d != state_q);

    mips16_ack_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .inc     (wd_inc),
        .limit   (TMO_W'(ACK_TIMEOUT)),
        .expired (wd_expired)
    );

    // Every output is gated by reset_n so no enable can leak during reset.
    always_comb begin
        state_d      = state_q;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS1;
        reg_write    = 1'b0;
        reg_dst      = DST_RT;
        mem_to_reg   = M2R_ALU;
        alu_op       = ALU_ADD;
        alu_src      = 1'b0;
        sign_or_zero = 1'b1;
        retire       = 1'b0;
        fault        = 1'b0;

        if (reset_n) begin
            if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
                case (op_q)
                    OP_SLTI: begin
                        alu_op       = ALU_SLT;
                        alu_src      = 1'b1;
                        sign_or_zero = 1'b0;
                    end
                    OP_LW, OP_SW, OP_ADDI: begin
                        alu_op  = ALU_ADDI;
                        alu_src = 1'b1;
                    end
                    OP_BEQ:  alu_op = ALU_SUB;
                    default: alu_op = ALU_ADD;
                endcase
            end

            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_PLUS1;
                        state_d  = S_DECODE;
                    end else if (wd_expired) begin
                        state_d = S_FAULT;
                    end
                end
                S_DECODE: state_d = S_EXEC;
                S_EXEC: begin
                    case (op_q)
                        OP_J: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_JAL: begin
                            pc_write   = 1'b1;
                            pc_src     = PC_JUMP;
                            reg_write  = 1'b1;
                            reg_dst    = DST_LINK;
                            mem_to_reg = M2R_PC1;
                            retire     = 1'b1;
                            state_d    = S_FETCH;
                        end
                        OP_BEQ: begin
                            pc_write = alu_zero;
                            pc_src   = PC_BRANCH;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_LW, OP_SW: state_d = S_MEM;
                        default:      state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_q == OP_SW);
                    if (dmem_ack) begin
                        if (op_q == OP_SW) begin
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wd_expired) begin
                        state_d = S_FAULT;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    case (op_q)
                        OP_R:    reg_dst = DST_RD;
                        OP_LW:   mem_to_reg = M2R_MDR;
                        default: reg_dst = DST_RT;
                    endcase
                    state_d = S_FETCH;
                end
                S_FAULT: fault = 1'b1;
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state_o = state_q;

`ifdef MIPS16_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (state_q != S_FAULT) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips16_multicycle_ctrl.sv
// Directed self-checking bench for mips16_multicycle_ctrl (timeout set to 4 cycles).
module tb_mips16_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n, alu_zero, imem_ack, dmem_ack;
    logic [2:0] opcode;

    logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_op;
    logic       reg_write, alu_src, sign_or_zero, retire, fault;
    logic [2:0] state_o;
`ifdef MIPS16_CTRL_PERF_EN
    logic [31:0] cycle_cnt, retire_cnt;
`endif

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       sign_or_zero;
        logic       retire;
        logic       fault;
        logic [2:0] state;
    } ctl_t;

    ctl_t obs, e;
    int   checks = 0;
    int   failures = 0;

    assign obs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write,
                  reg_dst, mem_to_reg, alu_op, alu_src, sign_or_zero, retire, fault, state_o};

    always #5 clk = ~clk;

    mips16_multicycle_ctrl #(
        .ACK_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .alu_zero     (alu_zero),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .sign_or_zero (sign_or_zero),
        .retire       (retire),
        .fault        (fault),
        .state_o      (state_o)
`ifdef MIPS16_CTRL_PERF_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt)
`endif
    );

    function automatic ctl_t base(input logic [2:0] st);
        ctl_t c;
        c = '0;
        c.sign_or_zero = 1'b1;
        c.state = st;
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs FETCH (with ack) and DECODE; returns at the start of the EXEC cycle.
    task automatic fetch(input logic [2:0] op);
        opcode = op;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; opcode = 3'd0;
        #2; e = base(3'd0);
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL reset_outputs got=%h exp=%h", obs, e); end
        tick();
        #2;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL reset_held got=%h exp=%h", obs, e); end
        tick();
        reset_n = 1'b1;
        #2; e = base(3'd0); e.imem_req = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL reset_release got=%h exp=%h", obs, e); end
        tick();
    endtask

    task automatic test_r_type;
        opcode = 3'd0; imem_ack = 1'b1;
        #2; e = base(3'd0); e.imem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL r_fetch got=%h exp=%h", obs, e); end
        tick(); imem_ack = 1'b0;
        #2; e = base(3'd1);
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL r_decode got=%h exp=%h", obs, e); end
        tick();
        #2; e = base(3'd2);
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL r_exec got=%h exp=%h", obs, e); end
        tick();
        #2; e = base(3'd4); e.reg_write = 1'b1; e.reg_dst = 2'b01; e.retire = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL r_wb got=%h exp=%h", obs, e); end
        tick();
        #2; e = base(3'd0); e.imem_req = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL r_next_fetch got=%h exp=%h", obs, e); end
    endtask

    task automatic test_lw;
        fetch(3'd4);
        #2; e = base(3'd2); e.alu_op = 2'b11; e.alu_src = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL lw_exec got=%h exp=%h", obs, e); end
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #2; e = base(3'd3); e.dmem_req = 1'b1; e.alu_op = 2'b11; e.alu_src = 1'b1;
            checks++; if (obs !== e) begin failures++; $display("[TB] FAIL lw_mem_%0d got=%h exp=%h", i, obs, e); end
            tick();
        end
        dmem_ack = 1'b0;
        #2; e = base(3'd4); e.reg_write = 1'b1; e.mem_to_reg = 2'b01; e.retire = 1'b1;
        e.alu_op = 2'b11; e.alu_src = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL lw_wb got=%h exp=%h", obs, e); end
        tick();
        #2; e = base(3'd0); e.imem_req = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL lw_next_fetch got=%h exp=%h", obs, e); end
    endtask

    task automatic test_sw;
        fetch(3'd5);
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #2; e = base(3'd3); e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.alu_op = 2'b11; e.alu_src = 1'b1;
            e.retire = (i == 3);
            checks++; if (obs !== e) begin failures++; $display("[TB] FAIL sw_mem_%0d got=%h exp=%h", i, obs, e); end
            tick();
        end
        dmem_ack = 1'b0;
        #2; e = base(3'd0); e.imem_req = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL sw_no_wb got=%h exp=%h", obs, e); end
    endtask

    task automatic test_branch_jump;
        fetch(3'd6); alu_zero = 1'b1;
        #2; e = base(3'd2); e.alu_op = 2'b01; e.pc_write = 1'b1; e.pc_src = 2'b01; e.retire = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL beq_taken got=%h exp=%h", obs, e); end
        tick(); alu_zero = 1'b0;
        #2; e = base(3'd0); e.imem_req = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL beq_next_fetch got=%h exp=%h", obs, e); end
        fetch(3'd6);
        #2; e = base(3'd2); e.alu_op = 2'b01; e.pc_src = 2'b01; e.retire = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL beq_not_taken got=%h exp=%h", obs, e); end
        tick();
        fetch(3'd3);
        #2; e = base(3'd2); e.pc_write = 1'b1; e.pc_src = 2'b10; e.reg_write = 1'b1;
        e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.retire = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL jal_exec got=%h exp=%h", obs, e); end
        tick();
    endtask

    task automatic test_slti;
        fetch(3'd1);
        #2; e = base(3'd2); e.alu_op = 2'b10; e.alu_src = 1'b1; e.sign_or_zero = 1'b0;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL slti_exec got=%h exp=%h", obs, e); end
        tick();
        #2; e.state = 3'd4; e.reg_write = 1'b1; e.retire = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL slti_wb got=%h exp=%h", obs, e); end
        tick();
    endtask

    task automatic test_timeout;
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2; e = base(3'd0); e.imem_req = 1'b1;
            checks++; if (obs !== e) begin failures++; $display("[TB] FAIL tmo_wait_%0d got=%h exp=%h", i, obs, e); end
            tick();
        end
        #2; e = base(3'd5); e.fault = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL tmo_fault got=%h exp=%h", obs, e); end
        imem_ack = 1'b1; dmem_ack = 1'b1;
        tick(); tick(); tick();
        #2;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL tmo_sticky got=%h exp=%h", obs, e); end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        reset_n = 1'b0;
        #1; e = base(3'd0);
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL tmo_reset got=%h exp=%h", obs, e); end
        tick();
        reset_n = 1'b1;
        #2; e = base(3'd0); e.imem_req = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL tmo_resume got=%h exp=%h", obs, e); end
        tick();
    endtask

    task automatic test_reset_mid_mem;
        fetch(3'd4);
        tick();
        #2; e = base(3'd3); e.dmem_req = 1'b1; e.alu_op = 2'b11; e.alu_src = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL mm_in_mem got=%h exp=%h", obs, e); end
        reset_n = 1'b0;
        #1; e = base(3'd0);
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL mm_reset_drop got=%h exp=%h", obs, e); end
        tick();
        reset_n = 1'b1; dmem_ack = 1'b1;
        #2; e = base(3'd0); e.imem_req = 1'b1;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL mm_spurious got=%h exp=%h", obs, e); end
        tick();
        #2;
        checks++; if (obs !== e) begin failures++; $display("[TB] FAIL mm_spurious_hold got=%h exp=%h", obs, e); end
        dmem_ack = 1'b0;
        tick();
    endtask

`ifdef MIPS16_CTRL_PERF_EN
    task automatic test_perf;
        reset_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b0; opcode = 3'd7;
        tick();
        reset_n = 1'b1;
        repeat (40) tick();
        #2;
        checks++; if (retire_cnt !== 32'd10) begin failures++; $display("[TB] FAIL perf_retire got=%0d exp=10", retire_cnt); end
        checks++; if (cycle_cnt !== 32'd40) begin failures++; $display("[TB] FAIL perf_cycle got=%0d exp=40", cycle_cnt); end
        imem_ack = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_r_type();
        test_lw();
        test_sw();
        test_branch_jump();
        test_slti();
        test_timeout();
        test_reset_mid_mem();
`ifdef MIPS16_CTRL_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL sim_time_limit got=expired exp=finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
